// File: rtl/spi_ram.sv
// SPI-side RAM: decodes 10-bit command words from the SPI slave into
// address/data writes and reads, and flags and counts out-of-order commands.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err,
    output logic [7:0] err_cnt
);

    localparam logic [8:0]           DEPTH_W   = 9'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 rx_valid_q;

    logic                 accept;
    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] addr_in;
    logic                 addr_in_range;
    logic                 do_wr_addr;
    logic                 do_wr_data;
    logic                 do_rd_addr;
    logic                 do_rd_data;
    logic                 reject;

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    // Only the rising edge of rx_valid carries a command; a held level is ignored.
    always_comb begin
        cmd           = din[9:8];
        payload       = din[7:0];
        addr_in       = din[ADDR_SIZE-1:0];
        addr_in_range = ({1'b0, payload} < DEPTH_W);
        accept        = rx_valid && !rx_valid_q;
        do_wr_addr    = 1'b0;
        do_wr_data    = 1'b0;
        do_rd_addr    = 1'b0;
        do_rd_data    = 1'b0;
        reject        = 1'b0;
        if (accept) begin
            case (cmd)
                2'b00: begin
                    do_wr_addr = addr_in_range;
                    reject     = !addr_in_range;
                end
                2'b01: begin
                    do_wr_data = wr_ok;
                    reject     = !wr_ok;
                end
                2'b10: begin
                    do_rd_addr = addr_in_range;
                    reject     = !addr_in_range;
                end
                default: begin
                    do_rd_data = rd_ok;
                    reject     = !rd_ok;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_ok      <= 1'b0;
            rd_ok      <= 1'b0;
            dout       <= 8'h00;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid;
            cmd_err    <= reject;
            if (reject && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;

            if (do_wr_addr) begin
                wr_addr <= addr_in;
                wr_ok   <= 1'b1;
            end else if (do_wr_data && AUTO_INC) begin
                wr_addr <= next_addr(wr_addr);
            end

            if (do_rd_addr) begin
                rd_addr <= addr_in;
                rd_ok   <= 1'b1;
            end else if (do_rd_data && AUTO_INC) begin
                rd_addr <= next_addr(rd_addr);
            end

            // Any accepted command ends the previous read's valid window.
            if (accept)
                tx_valid <= do_rd_data;
            if (do_rd_data)
                dout <= mem[rd_addr];
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr_data)
            mem[wr_addr] <= payload;
    end

endmodule
